// File: rtl/reg_file_pkg.sv
// Shared opcodes, GPO field positions, status bit map and memory-read FSM encoding
// for the multi-channel command/status register file.
package reg_file_pkg;

  localparam logic [7:0] OP_RESET    = 8'd0;
  localparam logic [7:0] OP_EN_TX    = 8'd1;
  localparam logic [7:0] OP_EN_RX    = 8'd2;
  localparam logic [7:0] OP_PH_SEL   = 8'd3;
  localparam logic [7:0] OP_RUN_MEM  = 8'd4;
  localparam logic [7:0] OP_READ_MEM = 8'd5;
  localparam logic [7:0] OP_ADDR_MEM = 8'd6;
  localparam logic [7:0] OP_BER_S    = 8'd7;
  localparam logic [7:0] OP_BER_E    = 8'd9;
  localparam logic [7:0] OP_BER_H    = 8'd11;
  localparam logic [7:0] OP_CH_SEL   = 8'd12;
  localparam logic [7:0] OP_STATUS   = 8'd14;

  localparam int GPO_OP_MSB = 31;
  localparam int GPO_OP_LSB = 24;
  localparam int GPO_STRB   = 23;
  localparam int GPO_PL_MSB = 22;
  localparam int GPO_PL_W   = GPO_PL_MSB + 1;

  typedef struct packed {
    logic [7:0]          opcode;
    logic                strobe;
    logic [GPO_PL_W-1:0] payload;
  } gpo_t;

  localparam int ST_ENB_TX      = 0;
  localparam int ST_ENB_RX      = 1;
  localparam int ST_RUN_LOG     = 2;
  localparam int ST_READ_LOG    = 3;
  localparam int ST_MEM_FULL    = 4;
  localparam int ST_MEM_BUSY    = 5;
  localparam int ST_ERR_BAD_OP  = 6;
  localparam int ST_LOG_STOPPED = 7;
  localparam int ST_CH_SEL_LSB  = 8;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_LOAD = 2'd2
  } mem_state_t;

endpackage

// File: rtl/ber_snapshot_bank.sv
// Lane mux plus coherent capture of both BER counters; low word is live, high word comes from the capture.
// Capture completes in one clock; no backpressure, a capture strobe always overwrites the previous snapshot.
module ber_snapshot_bank
  import reg_file_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int NB_BER = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*NB_BER-1:0] samp,
  input  logic [N_CH*NB_BER-1:0] err,
  input  logic [7:0]             lane,
  input  logic                   cap,
  input  logic                   cap_err,
  output logic [31:0]            lo_word,
  output logic [31:0]            hi_word
);

  logic [NB_BER-1:0] lane_samp;
  logic [NB_BER-1:0] lane_err;
  logic [NB_BER-1:0] samp_q;
  logic [NB_BER-1:0] err_q;
  logic              sel_err_q;
  logic [63:0]       hi_ext;

  always_comb begin
    lane_samp = samp[int'(lane) * NB_BER +: NB_BER];
    lane_err  = err[int'(lane) * NB_BER +: NB_BER];
    lo_word   = cap_err ? lane_err[31:0] : lane_samp[31:0];
  end

  // Both counters latch together so a later high read pairs with the low word just returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q    <= '0;
      err_q     <= '0;
      sel_err_q <= 1'b0;
    end else if (cap) begin
      samp_q    <= lane_samp;
      err_q     <= lane_err;
      sel_err_q <= cap_err;
    end
  end

  always_comb begin
    hi_ext               = '0;
    hi_ext[NB_BER-1:0]   = sel_err_q ? err_q : samp_q;
    hi_word              = hi_ext[63:32];
  end

endmodule

// File: rtl/reg_file_multich.sv
// GPIO command decode, sticky status, soft-reset pulse, log-memory read sequencer and BER readback.
// Commands act one clock after the strobe edge is sampled; no backpressure, one execution per strobe edge.
module reg_file_multich
  import reg_file_pkg::*;
#(
  parameter int NB_ADDR_MEM = 15,
  parameter int N_CH        = 2,
  parameter int NB_PHASE    = 2,
  parameter int NB_BER      = 64,
  parameter int MEM_LAT     = 2,
  parameter int RST_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic [31:0]            i_gpo,
  input  logic [31:0]            i_data_log_from_mem,
  input  logic                   i_mem_full,
  input  logic [N_CH*NB_BER-1:0] i_ber_samp,
  input  logic [N_CH*NB_BER-1:0] i_ber_error,
  output logic [31:0]            o_gpi,
  output logic                   o_rst,
  output logic                   o_enbTx,
  output logic                   o_enbRx,
  output logic [NB_PHASE-1:0]    o_phase_sel,
  output logic                   o_run_log,
  output logic                   o_read_log,
  output logic [NB_ADDR_MEM-1:0] o_addr_log_to_mem
);

  localparam int         RST_W    = $clog2(RST_CYCLES + 1);
  localparam logic [2:0] LAT_INIT = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

  gpo_t       gpo_q;
  logic       strb_prev;
  logic       full_q;
  logic       full_prev;
  logic       cmd_vld;
  logic       full_rise;
  logic       unused_pl;

  logic       cmd_reset;
  logic       cmd_en_tx;
  logic       cmd_en_rx;
  logic       cmd_ph_sel;
  logic       cmd_run_mem;
  logic       cmd_read_mem;
  logic       cmd_addr_mem;
  logic       cmd_ber_s;
  logic       cmd_ber_e;
  logic       cmd_ber_h;
  logic       cmd_ch_sel;
  logic       cmd_status;
  logic       bad_op;
  logic       cmd_snap;
  logic       cmd_gpi;

  logic [7:0]       ch_sel;
  logic             err_bad_op;
  logic             log_stopped;
  logic [RST_W-1:0] rst_cnt;
  logic             auto_stop;

  mem_state_t state_q;
  mem_state_t state_d;
  logic [2:0] lat_cnt_q;
  logic [2:0] lat_cnt_d;
  logic       mem_load;
  logic       mem_busy;

  logic [31:0] status_word;
  logic [31:0] ber_lo;
  logic [31:0] ber_hi;

  // Strobe and mem_full are registered first, then edge-detected against the previous sample.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gpo_q     <= '0;
      strb_prev <= 1'b0;
      full_q    <= 1'b0;
      full_prev <= 1'b0;
    end else begin
      gpo_q.opcode  <= i_gpo[GPO_OP_MSB:GPO_OP_LSB];
      gpo_q.strobe  <= i_gpo[GPO_STRB];
      gpo_q.payload <= i_gpo[GPO_PL_MSB:0];
      strb_prev     <= gpo_q.strobe;
      full_q        <= i_mem_full;
      full_prev     <= full_q;
    end
  end

  assign cmd_vld   = gpo_q.strobe & ~strb_prev;
  assign full_rise = full_q & ~full_prev;
  assign auto_stop = full_rise & o_run_log;
  assign unused_pl = ^gpo_q.payload;

  always_comb begin
    cmd_reset    = 1'b0;
    cmd_en_tx    = 1'b0;
    cmd_en_rx    = 1'b0;
    cmd_ph_sel   = 1'b0;
    cmd_run_mem  = 1'b0;
    cmd_read_mem = 1'b0;
    cmd_addr_mem = 1'b0;
    cmd_ber_s    = 1'b0;
    cmd_ber_e    = 1'b0;
    cmd_ber_h    = 1'b0;
    cmd_ch_sel   = 1'b0;
    cmd_status   = 1'b0;
    bad_op       = 1'b0;
    if (cmd_vld) begin
      case (gpo_q.opcode)
        OP_RESET:    cmd_reset    = 1'b1;
        OP_EN_TX:    cmd_en_tx    = 1'b1;
        OP_EN_RX:    cmd_en_rx    = 1'b1;
        OP_PH_SEL:   cmd_ph_sel   = 1'b1;
        OP_RUN_MEM:  cmd_run_mem  = 1'b1;
        OP_READ_MEM: cmd_read_mem = 1'b1;
        OP_ADDR_MEM: cmd_addr_mem = 1'b1;
        OP_BER_S:    cmd_ber_s    = 1'b1;
        OP_BER_E:    cmd_ber_e    = 1'b1;
        OP_BER_H:    cmd_ber_h    = 1'b1;
        OP_STATUS:   cmd_status   = 1'b1;
        OP_CH_SEL: begin
          if (int'(gpo_q.payload[7:0]) < N_CH) cmd_ch_sel = 1'b1;
          else                                 bad_op     = 1'b1;
        end
        default:     bad_op       = 1'b1;
      endcase
    end
  end

  assign cmd_snap = cmd_ber_s | cmd_ber_e;
  assign cmd_gpi  = cmd_snap | cmd_ber_h | cmd_status;

  // Pulse-end clear is applied last so it overrides same-cycle enable writes.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_enbTx           <= 1'b0;
      o_enbRx           <= 1'b0;
      o_phase_sel       <= '0;
      o_run_log         <= 1'b0;
      o_read_log        <= 1'b0;
      o_addr_log_to_mem <= '0;
      ch_sel            <= '0;
      o_rst             <= 1'b0;
      rst_cnt           <= '0;
    end else begin
      if (cmd_en_tx)    o_enbTx           <= gpo_q.payload[0];
      if (cmd_en_rx)    o_enbRx           <= gpo_q.payload[0];
      if (cmd_ph_sel)   o_phase_sel       <= gpo_q.payload[NB_PHASE-1:0];
      if (cmd_read_mem) o_read_log        <= gpo_q.payload[0];
      if (cmd_addr_mem) o_addr_log_to_mem <= gpo_q.payload[NB_ADDR_MEM-1:0];
      if (cmd_ch_sel)   ch_sel            <= gpo_q.payload[7:0];
      if (cmd_run_mem && !(gpo_q.payload[0] && full_q))
        o_run_log <= gpo_q.payload[0];
      if (auto_stop)
        o_run_log <= 1'b0;

      if (cmd_reset) begin
        rst_cnt <= RST_W'(RST_CYCLES);
        o_rst   <= 1'b1;
      end else if (rst_cnt != '0) begin
        rst_cnt <= rst_cnt - 1'b1;
        if (rst_cnt == RST_W'(1)) begin
          o_rst      <= 1'b0;
          o_enbTx    <= 1'b0;
          o_enbRx    <= 1'b0;
          o_run_log  <= 1'b0;
          o_read_log <= 1'b0;
        end
      end
    end
  end

  // A status read clears the sticky flags; an event landing in the same cycle wins.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_bad_op  <= 1'b0;
      log_stopped <= 1'b0;
    end else begin
      if (cmd_status) begin
        err_bad_op  <= 1'b0;
        log_stopped <= 1'b0;
      end
      if (bad_op)    err_bad_op  <= 1'b1;
      if (auto_stop) log_stopped <= 1'b1;
    end
  end

  assign mem_busy = (state_q != MEM_IDLE);

  always_comb begin
    status_word                                 = '0;
    status_word[ST_ENB_TX]                      = o_enbTx;
    status_word[ST_ENB_RX]                      = o_enbRx;
    status_word[ST_RUN_LOG]                     = o_run_log;
    status_word[ST_READ_LOG]                    = o_read_log;
    status_word[ST_MEM_FULL]                    = full_q;
    status_word[ST_MEM_BUSY]                    = mem_busy;
    status_word[ST_ERR_BAD_OP]                  = err_bad_op;
    status_word[ST_LOG_STOPPED]                 = log_stopped;
    status_word[ST_CH_SEL_LSB +: 8]             = ch_sel;
  end

  ber_snapshot_bank #(
    .N_CH   (N_CH),
    .NB_BER (NB_BER)
  ) u_ber_bank (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .samp    (i_ber_samp),
    .err     (i_ber_error),
    .lane    (ch_sel),
    .cap     (cmd_snap),
    .cap_err (cmd_ber_e),
    .lo_word (ber_lo),
    .hi_word (ber_hi)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= MEM_IDLE;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // LOAD is the cycle the read data is valid; a new address restarts, a GPI command aborts.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    mem_load  = 1'b0;
    case (state_q)
      MEM_WAIT: begin
        if (lat_cnt_q == 3'd0) state_d   = MEM_LOAD;
        else                   lat_cnt_d = lat_cnt_q - 3'd1;
      end
      MEM_LOAD: begin
        mem_load = 1'b1;
        state_d  = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
    if (cmd_addr_mem) begin
      state_d   = (MEM_LAT == 0) ? MEM_LOAD : MEM_WAIT;
      lat_cnt_d = LAT_INIT;
      mem_load  = 1'b0;
    end else if (cmd_gpi) begin
      state_d   = MEM_IDLE;
      lat_cnt_d = '0;
      mem_load  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)        o_gpi <= '0;
    else if (cmd_snap)   o_gpi <= ber_lo;
    else if (cmd_ber_h)  o_gpi <= ber_hi;
    else if (cmd_status) o_gpi <= status_word;
    else if (mem_load)   o_gpi <= i_data_log_from_mem;
  end

endmodule

// File: tb/tb_reg_file_multich.sv
// Directed bench for reg_file_multich with four BER lanes and a two-cycle log-memory latency.
module tb_reg_file_multich;

  logic           clk = 1'b0;
  logic           i_rst_n;
  logic [31:0]    i_gpo;
  logic [31:0]    i_data_log_from_mem;
  logic           i_mem_full;
  logic [255:0]   i_ber_samp;
  logic [255:0]   i_ber_error;
  logic [31:0]    o_gpi;
  logic           o_rst;
  logic           o_enbTx;
  logic           o_enbRx;
  logic [1:0]     o_phase_sel;
  logic           o_run_log;
  logic           o_read_log;
  logic [14:0]    o_addr_log_to_mem;

  int n_checks = 0;
  int n_fail   = 0;
  int hi_cnt;
  int first_hi;

  always #5 clk = ~clk;

  reg_file_multich #(
    .NB_ADDR_MEM (15),
    .N_CH        (4),
    .NB_PHASE    (2),
    .NB_BER      (64),
    .MEM_LAT     (2),
    .RST_CYCLES  (4)
  ) dut (
    .clk                 (clk),
    .i_rst_n             (i_rst_n),
    .i_gpo               (i_gpo),
    .i_data_log_from_mem (i_data_log_from_mem),
    .i_mem_full          (i_mem_full),
    .i_ber_samp          (i_ber_samp),
    .i_ber_error         (i_ber_error),
    .o_gpi               (o_gpi),
    .o_rst               (o_rst),
    .o_enbTx             (o_enbTx),
    .o_enbRx             (o_enbRx),
    .o_phase_sel         (o_phase_sel),
    .o_run_log           (o_run_log),
    .o_read_log          (o_read_log),
    .o_addr_log_to_mem   (o_addr_log_to_mem)
  );

  function automatic logic [31:0] gpo(input logic [7:0] op, input logic stb, input logic [22:0] pl);
    return {op, stb, pl};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe is seen at edge t; returns at the falling edge after t+1.
  task automatic send(input logic [7:0] op, input logic [22:0] pl);
    @(negedge clk); i_gpo = gpo(op, 1'b1, pl);
    @(negedge clk); i_gpo = gpo(op, 1'b0, pl);
    @(negedge clk);
  endtask

  initial begin
    i_rst_n             = 1'b0;
    i_gpo               = '0;
    i_data_log_from_mem = 32'hCAFE_0001;
    i_mem_full          = 1'b0;
    i_ber_samp          = '0;
    i_ber_error         = '0;
    i_ber_samp[0*64 +: 64]  = 64'h0000_0022_0000_0011;
    i_ber_samp[2*64 +: 64]  = 64'h0000_0001_FFFF_FFFF;
    i_ber_error[2*64 +: 64] = 64'h0000_00AB_0000_0005;

    repeat (3) @(negedge clk);
    check("rst_gpi",   o_gpi, 0);
    check("rst_orst",  o_rst, 0);
    check("rst_entx",  o_enbTx, 0);
    check("rst_phase", o_phase_sel, 0);
    check("rst_addr",  o_addr_log_to_mem, 0);
    i_rst_n = 1'b1;

    send(8'd1, 23'd1);  check("en_tx",    o_enbTx, 1);
    send(8'd3, 23'd3);  check("ph_sel",   o_phase_sel, 3);
    send(8'd2, 23'd1);  check("en_rx",    o_enbRx, 1);
    send(8'd5, 23'd1);  check("read_mem", o_read_log, 1);

    // RESET strobe held for five clocks must give a single four-cycle pulse.
    i_gpo    = gpo(8'd0, 1'b1, 23'd0);
    hi_cnt   = 0;
    first_hi = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_rst) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end
      if (i == 4) i_gpo = gpo(8'd0, 1'b0, 23'd0);
    end
    check("srst_len",     hi_cnt, 4);
    check("srst_start",   first_hi, 1);
    check("srst_entx",    o_enbTx, 0);
    check("srst_enrx",    o_enbRx, 0);
    check("srst_readlog", o_read_log, 0);
    check("srst_phase",   o_phase_sel, 3);

    send(8'd0, 23'd0);
    send(8'd0, 23'd0);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_rst) hi_cnt++;
    end
    check("srst_extend", hi_cnt, 3);

    send(8'd12, 23'd2);
    send(8'd7, 23'd0);  check("ber_s_lo", o_gpi, 32'hFFFF_FFFF);
    i_ber_samp[2*64 +: 64] = 64'h0000_0002_0000_0000;
    send(8'd11, 23'd0); check("ber_s_hi", o_gpi, 32'h0000_0001);
    send(8'd9, 23'd0);  check("ber_e_lo", o_gpi, 32'h0000_0005);
    send(8'd11, 23'd0); check("ber_e_hi", o_gpi, 32'h0000_00AB);
    send(8'd12, 23'd0);
    send(8'd7, 23'd0);  check("ber_lane0", o_gpi, 32'h0000_0011);

    send(8'd6, 23'h1234);
    check("mem_addr", o_addr_log_to_mem, 15'h1234);
    @(negedge clk);
    @(negedge clk);     check("mem_early", o_gpi, 32'h0000_0011);
    @(negedge clk);     check("mem_data",  o_gpi, 32'hCAFE_0001);

    // STATUS strobe seen two clocks after the address strobe aborts the read.
    i_data_log_from_mem = 32'hBAD0_0BAD;
    @(negedge clk); i_gpo = gpo(8'd6, 1'b1, 23'h0456);
    @(negedge clk); i_gpo = gpo(8'd6, 1'b0, 23'h0456);
    @(negedge clk); i_gpo = gpo(8'd14, 1'b1, 23'd0);
    @(negedge clk); i_gpo = gpo(8'd14, 1'b0, 23'd0);
    @(negedge clk);     check("abort_status", o_gpi, 32'h0000_0020);
    check("abort_addr", o_addr_log_to_mem, 15'h0456);
    repeat (3) @(negedge clk);
    check("abort_hold", o_gpi, 32'h0000_0020);

    send(8'd4, 23'd1);  check("run_log_on", o_run_log, 1);
    i_mem_full = 1'b1;
    @(negedge clk);     check("autostop_pre",  o_run_log, 1);
    @(negedge clk);     check("autostop_post", o_run_log, 0);
    send(8'd4, 23'd1);  check("run_while_full", o_run_log, 0);
    send(8'd14, 23'd0); check("status_stopped", o_gpi, 32'h0000_0090);
    send(8'd14, 23'd0); check("status_cleared", o_gpi, 32'h0000_0010);
    i_mem_full = 1'b0;

    send(8'd12, 23'd3);
    send(8'd8, 23'd0);
    send(8'd12, 23'd9);
    send(8'd14, 23'd0); check("status_badop", o_gpi, 32'h0000_0340);
    send(8'd14, 23'd0); check("status_badop_clr", o_gpi, 32'h0000_0300);

    send(8'd1, 23'd1);
    send(8'd0, 23'd0);
    check("pre_arst_orst", o_rst, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_orst",  o_rst, 0);
    check("arst_entx",  o_enbTx, 0);
    check("arst_phase", o_phase_sel, 0);
    check("arst_gpi",   o_gpi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
